// File: rtl/lane_note_scheduler.sv
// Falling-note scheduler for one piano lane.
// Walks the lane's chart ROM and spawns a block into the lowest free slot
// once the song beat reaches each note's beat. Every clock it moves the live
// blocks down one line and retires blocks that are hit or reach the bottom.
module lane_note_scheduler #(
    parameter int SLOTS    = 4,
    parameter int CHART_AW = 6,
    parameter int H_SPAWN  = 120,
    parameter int H_END    = 720,
    localparam int SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic                  stop_or_endgame,
    input  logic [6:0]            beat_cnt,
    output logic [CHART_AW-1:0]   chart_addr,
    input  logic [6:0]            chart_beat,
    input  logic                  chart_valid,
    input  logic                  hit_valid,
    input  logic [SW-1:0]         hit_slot,
    output logic [10*SLOTS-1:0]   slot_h,
    output logic [SLOTS-1:0]      slot_active,
    output logic                  miss,
    output logic                  overflow,
    output logic                  chart_done
);

    localparam logic [9:0] H_SPAWN_H = 10'(H_SPAWN);
    localparam logic [9:0] H_END_H   = 10'(H_END);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [CHART_AW-1:0]   chart_addr_reg, chart_addr_next;
    logic                  miss_reg, miss_next;
    logic                  overflow_reg, overflow_next;

    logic [SLOTS-1:0]      active_vec;     // registered slot_active, also the free mask
    logic [SLOTS-1:0]      retire_vec;     // slots retiring at the bottom this clock
    logic [SLOTS-1:0]      spawn_onehot;   // lowest free slot
    logic                  any_free;
    logic                  walk;
    logic                  consume;
    logic                  addr_max;

    assign addr_max = &chart_addr_reg;
    assign walk     = (state_reg == ST_RUN) && !stop_or_endgame;
    // A chart entry is consumed whenever its beat has arrived, including late
    // entries whose beat was skipped; this never stalls on a full pool.
    assign consume  = walk && chart_valid && (chart_beat <= beat_cnt);

    // Next-state and chart-walk decode
    always_comb begin
        state_next      = state_reg;
        chart_addr_next = chart_addr_reg;
        case (state_reg)
            ST_RUN: begin
                if (stop_or_endgame) begin
                    state_next = ST_HOLD;
                end else if (!chart_valid) begin
                    state_next = ST_DONE;
                end else if (consume) begin
                    // The last ROM address is still consumed, then the walk ends.
                    if (addr_max) begin
                        state_next = ST_DONE;
                    end else begin
                        chart_addr_next = chart_addr_reg + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!stop_or_endgame) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Lowest-index free slot, judged on the registered mask so a slot that is
    // retiring this clock is only reusable from the next one.
    always_comb begin
        spawn_onehot = '0;
        any_free     = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!active_vec[i] && !any_free) begin
                spawn_onehot[i] = 1'b1;
                any_free        = 1'b1;
            end
        end
    end

    // One miss pulse however many slots retire together; overflow is sticky
    always_comb begin
        miss_next     = |retire_vec;
        overflow_next = overflow_reg | (consume && !any_free);
    end

    // FSM, chart address and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            chart_addr_reg <= '0;
            miss_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else if (restart) begin
            state_reg      <= ST_RUN;
            chart_addr_reg <= '0;
            miss_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            chart_addr_reg <= chart_addr_next;
            miss_reg       <= miss_next;
            overflow_reg   <= overflow_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [9:0] h_reg, h_next;
            logic       act_reg, act_next;
            logic       hit_here;
            logic       at_end;
            logic       spawn_here;

            // Out-of-range slot indices never match any gi, so they are ignored.
            assign hit_here   = hit_valid && (hit_slot == SW'(gi)) && act_reg;
            assign at_end     = act_reg && (h_reg == H_END_H);
            assign spawn_here = consume && spawn_onehot[gi];

            // Per-slot update: hit beats bottom retirement, then motion, then spawn.
            // Spawn only targets inactive slots so it never collides with the others.
            always_comb begin
                h_next   = h_reg;
                act_next = act_reg;
                if (hit_here) begin
                    act_next = 1'b0;
                    h_next   = H_END_H;
                end else if (at_end) begin
                    act_next = 1'b0;
                end else if (act_reg && !stop_or_endgame && (h_reg < H_END_H)) begin
                    h_next = h_reg + 10'd1;
                end else if (spawn_here) begin
                    act_next = 1'b1;
                    h_next   = H_SPAWN_H;
                end
            end

            // Slot height and liveness registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    h_reg   <= H_END_H;
                    act_reg <= 1'b0;
                end else if (restart) begin
                    h_reg   <= H_END_H;
                    act_reg <= 1'b0;
                end else begin
                    h_reg   <= h_next;
                    act_reg <= act_next;
                end
            end

            assign retire_vec[gi]       = at_end && !hit_here;
            assign active_vec[gi]       = act_reg;
            assign slot_h[10*gi +: 10]  = h_reg;
            assign slot_active[gi]      = act_reg;
        end
    endgenerate

    assign chart_addr = chart_addr_reg;
    assign miss       = miss_reg;
    assign overflow   = overflow_reg;
    assign chart_done = (state_reg == ST_DONE) && (active_vec == '0);

endmodule

// File: tb/tb_lane_note_scheduler.sv
// Self-checking bench for lane_note_scheduler: directed scenarios with literal
// expectations plus randomized charts, stops and hits checked every cycle
// against a slot-pool model.
module tb_lane_note_scheduler;

    localparam int NS   = 4;
    localparam int AW   = 6;
    localparam int HSP  = 120;
    localparam int HEND = 720;
    localparam int ROMN = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              restart;
    logic              stop_or_endgame;
    logic [6:0]        beat_cnt;
    logic [AW-1:0]     chart_addr;
    logic [6:0]        chart_beat;
    logic              chart_valid;
    logic              hit_valid;
    logic [1:0]        hit_slot;
    logic [10*NS-1:0]  slot_h;
    logic [NS-1:0]     slot_active;
    logic              miss;
    logic              overflow;
    logic              chart_done;

    // Chart ROM, asynchronous read
    logic              rom_v [ROMN];
    logic [6:0]        rom_b [ROMN];
    assign chart_valid = rom_v[chart_addr];
    assign chart_beat  = rom_b[chart_addr];

    lane_note_scheduler #(.SLOTS(NS), .CHART_AW(AW), .H_SPAWN(HSP), .H_END(HEND)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .restart         (restart),
        .stop_or_endgame (stop_or_endgame),
        .beat_cnt        (beat_cnt),
        .chart_addr      (chart_addr),
        .chart_beat      (chart_beat),
        .chart_valid     (chart_valid),
        .hit_valid       (hit_valid),
        .hit_slot        (hit_slot),
        .slot_h          (slot_h),
        .slot_active     (slot_active),
        .miss            (miss),
        .overflow        (overflow),
        .chart_done      (chart_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Model: pool of slots with heights, the chart read pointer, and whether
    // the walk has ended. A walk step is allowed only when stop is low now and
    // was low on the previous clock (resuming costs one clock).
    int         m_h [NS];
    logic [NS-1:0] m_act;
    int         m_addr;
    bit         m_done, m_ovf, m_miss, m_stop_prev;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_h[i] = HEND;
        m_act = '0;
        m_addr = 0;
        m_done = 0;
        m_ovf = 0;
        m_miss = 0;
        m_stop_prev = 0;
    endtask

    task automatic model_step();
        logic [NS-1:0] a0;
        bit walk;
        int f;
        if (!rst_n || restart) begin
            model_reset();
            return;
        end
        a0 = m_act;
        m_miss = 0;
        for (int i = 0; i < NS; i++) begin
            if (hit_valid && (int'(hit_slot) == i) && a0[i]) begin
                m_act[i] = 0;
                m_h[i] = HEND;
            end else if (a0[i] && m_h[i] == HEND) begin
                m_act[i] = 0;
                m_miss = 1;
            end else if (a0[i] && !stop_or_endgame) begin
                m_h[i] = m_h[i] + 1;
            end
        end
        walk = !m_done && !stop_or_endgame && !m_stop_prev;
        if (walk) begin
            if (!rom_v[m_addr]) begin
                m_done = 1;
            end else if (rom_b[m_addr] <= beat_cnt) begin
                f = -1;
                for (int i = 0; i < NS; i++) if (!a0[i] && f < 0) f = i;
                if (f >= 0) begin
                    m_act[f] = 1;
                    m_h[f] = HSP;
                end else begin
                    m_ovf = 1;
                end
                if (m_addr == ROMN - 1) m_done = 1;
                else m_addr = m_addr + 1;
            end
        end
        m_stop_prev = stop_or_endgame;
    endtask

    function automatic logic [10*NS-1:0] m_pack();
        logic [10*NS-1:0] p;
        for (int i = 0; i < NS; i++) p[10*i +: 10] = 10'(m_h[i]);
        return p;
    endfunction

    // Per-cycle compare process
    always @(posedge clk) begin
        model_step();
        #1;
        if (chk_en) begin
            chk("slot_h", 64'(slot_h), 64'(m_pack()));
            chk("slot_active", 64'(slot_active), 64'(m_act));
            chk("miss", 64'(miss), 64'(m_miss));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("chart_addr", 64'(chart_addr), 64'(m_addr));
            chk("chart_done", 64'(chart_done), 64'(m_done && m_act == '0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chart_clear();
        for (int i = 0; i < ROMN; i++) begin
            rom_v[i] = 1'b0;
            rom_b[i] = 7'd0;
        end
    endtask

    task automatic chart_set(input int idx, input int b);
        rom_v[idx] = 1'b1;
        rom_b[idx] = 7'(b);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        cyc();
        restart = 1'b0;
    endtask

    initial begin
        int n, b;
        rst_n = 1'b0; restart = 1'b0; stop_or_endgame = 1'b0;
        beat_cnt = 7'd0; hit_valid = 1'b0; hit_slot = 2'd0;
        chart_clear();
        chart_set(0, 1);
        chart_set(1, 19);
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk_en = 1;

        // Reset state
        chk("rst_active", 64'(slot_active), 64'd0);
        chk("rst_addr", 64'(chart_addr), 64'd0);
        chk("rst_h", 64'(slot_h), 64'({NS{10'd720}}));
        chk("rst_done", 64'(chart_done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // First note waits for beat 1, then spawns into slot 0
        cyc();
        chk("wait_addr", 64'(chart_addr), 64'd0);
        chk("wait_active", 64'(slot_active), 64'd0);
        beat_cnt = 7'd1;
        cyc();
        chk("spawn_active", 64'(slot_active), 64'd1);
        chk("spawn_h", 64'(slot_h[9:0]), 64'd120);
        chk("spawn_addr", 64'(chart_addr), 64'd1);

        // Fall to the bottom and retire as a miss
        repeat (599) cyc();
        chk("fall_h719", 64'(slot_h[9:0]), 64'd719);
        cyc();
        chk("fall_h720", 64'(slot_h[9:0]), 64'd720);
        chk("fall_act_still", 64'(slot_active), 64'd1);
        chk("fall_nomiss", 64'(miss), 64'd0);
        cyc();
        chk("retire_act", 64'(slot_active), 64'd0);
        chk("retire_miss", 64'(miss), 64'd1);
        cyc();
        chk("miss_pulse_end", 64'(miss), 64'd0);

        // Freeze for 50 clocks mid-flight, then resume exactly
        beat_cnt = 7'd19;
        cyc();
        chk("spawn2_addr", 64'(chart_addr), 64'd2);
        repeat (30) cyc();
        chk("pre_stop_h", 64'(slot_h[9:0]), 64'd150);
        stop_or_endgame = 1'b1;
        repeat (50) cyc();
        chk("stop_h", 64'(slot_h[9:0]), 64'd150);
        chk("stop_addr", 64'(chart_addr), 64'd2);
        stop_or_endgame = 1'b0;
        cyc();
        chk("resume_h", 64'(slot_h[9:0]), 64'd151);
        chk("resume_notdone", 64'(chart_done), 64'd0);

        // Five notes on one beat: four consecutive spawns, then overflow
        chart_clear();
        for (int i = 0; i < 5; i++) chart_set(i, 3);
        beat_cnt = 7'd0;
        do_restart();
        chk("rs_active", 64'(slot_active), 64'd0);
        chk("rs_addr", 64'(chart_addr), 64'd0);
        beat_cnt = 7'd3;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("burst_active", 64'(slot_active), 64'((1 << k) - 1));
            chk("burst_addr", 64'(chart_addr), 64'(k));
            chk("burst_no_ovf", 64'(overflow), 64'd0);
        end
        cyc();
        chk("burst_ovf", 64'(overflow), 64'd1);
        chk("burst_addr5", 64'(chart_addr), 64'd5);

        // Restart with live blocks clears everything next clock
        do_restart();
        chk("rs2_active", 64'(slot_active), 64'd0);
        chk("rs2_addr", 64'(chart_addr), 64'd0);
        chk("rs2_ovf", 64'(overflow), 64'd0);
        chk("rs2_h", 64'(slot_h), 64'({NS{10'd720}}));

        // Hit on slot 1 on the clock it would retire: freed, no miss
        chart_clear();
        chart_set(0, 0);
        chart_set(1, 0);
        beat_cnt = 7'd0;
        do_restart();
        cyc();
        chk("hs_act0", 64'(slot_active), 64'd1);
        cyc();
        chk("hs_act01", 64'(slot_active), 64'd3);
        repeat (599) cyc();
        chk("hs_h1_719", 64'(slot_h[19:10]), 64'd719);
        cyc();
        chk("hs_h1_720", 64'(slot_h[19:10]), 64'd720);
        chk("hs_slot0_miss", 64'(miss), 64'd1);
        chk("hs_act1_only", 64'(slot_active), 64'd2);
        hit_valid = 1'b1;
        hit_slot = 2'd1;
        cyc();
        hit_valid = 1'b0;
        chk("hit_freed", 64'(slot_active), 64'd0);
        chk("hit_nomiss", 64'(miss), 64'd0);
        chk("hit_h", 64'(slot_h[19:10]), 64'd720);
        chk("hit_chart_done", 64'(chart_done), 64'd1);

        // Randomized rounds; the last fills the whole ROM to hit address saturation
        for (int r = 0; r < 6; r++) begin
            chart_clear();
            n = (r == 5) ? ROMN : int'($urandom_range(5, 40));
            b = 0;
            for (int i = 0; i < n; i++) begin
                b = b + ((r == 5) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3)));
                if (b > 127) b = 127;
                chart_set(i, b);
            end
            beat_cnt = 7'd0;
            stop_or_endgame = 1'b0;
            do_restart();
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 7) == 0 && beat_cnt != 7'd127) beat_cnt = beat_cnt + 7'd1;
                if ($urandom_range(0, 99) < 4) stop_or_endgame = ~stop_or_endgame;
                hit_valid = ($urandom_range(0, 9) == 0);
                hit_slot = 2'($urandom_range(0, 3));
                if (r == 2 && c == 700) begin
                    // Asynchronous reset asserted between clock edges
                    #3;
                    rst_n = 1'b0;
                    #1;
                    model_reset();
                    chk("async_active", 64'(slot_active), 64'd0);
                    chk("async_addr", 64'(chart_addr), 64'd0);
                    chk("async_h", 64'(slot_h), 64'({NS{10'd720}}));
                    cyc();
                    rst_n = 1'b1;
                end
                cyc();
            end
            hit_valid = 1'b0;
            stop_or_endgame = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
